// File: rtl/lc3_pkg.sv
// Shared types and helpers for the LC-3 register file slice: sweep FSM states,
// condition-code encoding and the value classifier used by the CC unit.
package lc3_pkg;

  typedef enum logic [0:0] {
    CLEAR,
    READY
  } rf_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam nzp_t NZP_RESET = nzp_t'(3'b010);

  // Widest data path the classifier accepts.
  localparam int unsigned NZP_MAX_W = 64;

  // The caller must zero-extend value above width so the zero test stays exact.
  function automatic nzp_t nzp_of(input logic [NZP_MAX_W-1:0] value, input int unsigned width);
    logic [NZP_MAX_W-1:0] shifted;
    nzp_t                 r;
    shifted = value >> (width - 1);
    r.n     = shifted[0];
    r.z     = (value == '0);
    r.p     = ~r.n & ~r.z;
    return r;
  endfunction

endpackage

// File: rtl/lc3_cc_unit.sv
// Condition-code (NZP) and branch-enable registers. BEN always evaluates against
// the registered NZP, so a same-edge LD_CC does not affect it.
module lc3_cc_unit
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_CC,
  input  logic [DATA_W-1:0] CC_SRC,
  input  logic              LD_BEN,
  input  logic [2:0]        NZP_MASK,
  output logic [2:0]        NZP,
  output logic              BEN
);

  nzp_t                 nzp_q, nzp_d;
  logic                 ben_q, ben_d;
  logic [NZP_MAX_W-1:0] cc_ext;

  always_comb begin
    cc_ext               = '0;
    cc_ext[DATA_W-1:0]   = CC_SRC;
    nzp_d                = nzp_q;
    ben_d                = ben_q;
    if (LD_CC) begin
      nzp_d = nzp_of(cc_ext, DATA_W);
    end
    if (LD_BEN) begin
      ben_d = |(NZP_MASK & nzp_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      nzp_q <= NZP_RESET;
      ben_q <= 1'b0;
    end else begin
      nzp_q <= nzp_d;
      ben_q <= ben_d;
    end
  end

  assign NZP = nzp_q;
  assign BEN = ben_q;

endmodule

// File: rtl/lc3_regfile_sync.sv
// LC-3 register file on synchronous block RAM with a post-reset clear sweep, plus NZP/BEN.
// Define LC3_REGFILE_WRITE_BYPASS_EN for write-first same-edge collisions (default read-first).
module lc3_regfile_sync
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_REG,
  input  logic [ADDR_W-1:0] DR,
  input  logic [DATA_W-1:0] D,
  input  logic              RD_EN,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  output logic [DATA_W-1:0] SR1_out,
  output logic [DATA_W-1:0] SR2_out,
  output logic              RD_VALID,
  output logic              BUSY,
  input  logic              LD_CC,
  input  logic [DATA_W-1:0] CC_SRC,
  input  logic              LD_BEN,
  input  logic [2:0]        NZP_MASK,
  output logic [2:0]        NZP,
  output logic              BEN
);

  if (DATA_W < 2 || DATA_W > NZP_MAX_W) begin : g_bad_width
    $error("lc3_regfile_sync: unsupported DATA_W");
  end

  logic [DATA_W-1:0] regs_q [NREGS];

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
  logic              rd_valid_q, rd_valid_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              byp1, byp2;

`ifdef LC3_REGFILE_WRITE_BYPASS_EN
  assign byp1 = LD_REG && (DR == SR1);
  assign byp2 = LD_REG && (DR == SR2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    sr1_d      = sr1_q;
    sr2_d      = sr2_q;
    rd_valid_d = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = DR;
    wr_data    = D;
    unique case (state_q)
      CLEAR: begin
        wr_en     = 1'b1;
        wr_addr   = clr_ptr_q;
        wr_data   = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(NREGS - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        wr_en = LD_REG;
        if (RD_EN) begin
          rd_valid_d = 1'b1;
          sr1_d      = byp1 ? D : regs_q[SR1];
          sr2_d      = byp2 ? D : regs_q[SR2];
        end
      end
    endcase
    // Reset edges never touch the array; the sweep that follows clears it.
    if (Reset) begin
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      sr1_q      <= '0;
      sr2_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      sr1_q      <= sr1_d;
      sr2_q      <= sr2_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign SR1_out  = sr1_q;
  assign SR2_out  = sr2_q;
  assign RD_VALID = rd_valid_q;
  assign BUSY     = (state_q == CLEAR);

  lc3_cc_unit #(
    .DATA_W(DATA_W)
  ) u_cc (
    .Clk     (Clk),
    .Reset   (Reset),
    .LD_CC   (LD_CC),
    .CC_SRC  (CC_SRC),
    .LD_BEN  (LD_BEN),
    .NZP_MASK(NZP_MASK),
    .NZP     (NZP),
    .BEN     (BEN)
  );

endmodule

// File: tb/tb_lc3_regfile_sync.sv
// Bench for lc3_regfile_sync: a cycle model checked every cycle on the default
// build, directed literal checks, and a 32-bit/16-register instance.
module tb_lc3_regfile_sync;

  localparam int unsigned DW  = 16;
  localparam int unsigned NR  = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned WDW = 32;
  localparam int unsigned WNR = 16;
  localparam int unsigned WAW = 4;

`ifdef LC3_REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Reset = 1'b1;
  logic          LD_REG = 1'b0, RD_EN = 1'b0, LD_CC = 1'b0, LD_BEN = 1'b0;
  logic [AW-1:0] DR = '0, SR1 = '0, SR2 = '0;
  logic [DW-1:0] D = '0, CC_SRC = '0;
  logic [2:0]    NZP_MASK = '0;
  logic [DW-1:0] SR1_out, SR2_out;
  logic          RD_VALID, BUSY, BEN;
  logic [2:0]    NZP;

  logic           w_Reset = 1'b1;
  logic           w_LD_REG = 1'b0, w_RD_EN = 1'b0, w_LD_CC = 1'b0, w_LD_BEN = 1'b0;
  logic [WAW-1:0] w_DR = '0, w_SR1 = '0, w_SR2 = '0;
  logic [WDW-1:0] w_D = '0, w_CC_SRC = '0;
  logic [2:0]     w_NZP_MASK = '0;
  logic [WDW-1:0] w_SR1_out, w_SR2_out;
  logic           w_RD_VALID, w_BUSY, w_BEN;
  logic [2:0]     w_NZP;

  lc3_regfile_sync dut (
    .Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .D(D), .RD_EN(RD_EN),
    .SR1(SR1), .SR2(SR2), .SR1_out(SR1_out), .SR2_out(SR2_out), .RD_VALID(RD_VALID),
    .BUSY(BUSY), .LD_CC(LD_CC), .CC_SRC(CC_SRC), .LD_BEN(LD_BEN), .NZP_MASK(NZP_MASK),
    .NZP(NZP), .BEN(BEN)
  );

  lc3_regfile_sync #(.DATA_W(WDW), .NREGS(WNR)) dut_w (
    .Clk(Clk), .Reset(w_Reset), .LD_REG(w_LD_REG), .DR(w_DR), .D(w_D), .RD_EN(w_RD_EN),
    .SR1(w_SR1), .SR2(w_SR2), .SR1_out(w_SR1_out), .SR2_out(w_SR2_out),
    .RD_VALID(w_RD_VALID), .BUSY(w_BUSY), .LD_CC(w_LD_CC), .CC_SRC(w_CC_SRC),
    .LD_BEN(w_LD_BEN), .NZP_MASK(w_NZP_MASK), .NZP(w_NZP), .BEN(w_BEN)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: busy is a countdown of remaining sweep cycles; the whole
  // array is known to be zero once it reaches zero.
  int            m_busy_left = 0;
  logic [DW-1:0] m_mem [NR];
  logic [DW-1:0] m_sr1, m_sr2;
  logic          m_valid, m_ben;
  logic [2:0]    m_nzp;
  logic          m_live = 1'b0;

  function automatic logic [2:0] classify(input logic [DW-1:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == '0) return 3'b010;
    return 3'b001;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_busy_left <= int'(NR);
      m_sr1       <= '0;
      m_sr2       <= '0;
      m_valid     <= 1'b0;
      m_nzp       <= 3'b010;
      m_ben       <= 1'b0;
      m_live      <= 1'b1;
    end else begin
      if (m_busy_left != 0) begin
        m_busy_left <= m_busy_left - 1;
        m_valid     <= 1'b0;
        if (m_busy_left == 1) begin
          for (int i = 0; i < int'(NR); i++) m_mem[i] <= '0;
        end
      end else begin
        if (LD_REG) m_mem[DR] <= D;
        m_valid <= RD_EN;
        if (RD_EN) begin
          m_sr1 <= (BYPASS && LD_REG && DR == SR1) ? D : m_mem[SR1];
          m_sr2 <= (BYPASS && LD_REG && DR == SR2) ? D : m_mem[SR2];
        end
      end
      if (LD_CC) m_nzp <= classify(CC_SRC);
      if (LD_BEN) m_ben <= ((m_nzp & NZP_MASK) != 3'b000);
    end
  end

  always @(negedge Clk) begin
    if (m_live) begin
      check("mdl_busy", 64'(BUSY), 64'(m_busy_left != 0));
      check("mdl_rd_valid", 64'(RD_VALID), 64'(m_valid));
      check("mdl_sr1_out", 64'(SR1_out), 64'(m_sr1));
      check("mdl_sr2_out", 64'(SR2_out), 64'(m_sr2));
      check("mdl_nzp", 64'(NZP), 64'(m_nzp));
      check("mdl_ben", 64'(BEN), 64'(m_ben));
    end
  end

  task automatic wait_busy(output int cyc);
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (BUSY && cyc < 100);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    repeat (3) @(negedge Clk);
    check("reset_busy", 64'(BUSY), 64'd1);
    check("reset_nzp", 64'(NZP), 64'(3'b010));
    check("reset_ben", 64'(BEN), 64'd0);
    check("reset_rd_valid", 64'(RD_VALID), 64'd0);
    check("reset_sr1_out", 64'(SR1_out), 64'd0);

    Reset = 1'b0;
    wait_busy(cyc);
    check("sweep_len", 64'(cyc), 64'd8);

    SR1 = 3'd3; SR2 = 3'd7; RD_EN = 1'b1;
    @(negedge Clk);
    RD_EN = 1'b0;
    check("clr_valid", 64'(RD_VALID), 64'd1);
    check("clr_sr1", 64'(SR1_out), 64'd0);
    check("clr_sr2", 64'(SR2_out), 64'd0);
    @(negedge Clk);
    check("valid_pulse", 64'(RD_VALID), 64'd0);

    LD_REG = 1'b1; DR = 3'd2; D = 16'h1234;
    @(negedge Clk);
    DR = 3'd5; D = 16'hBEEF;
    @(negedge Clk);
    LD_REG = 1'b0; SR1 = 3'd2; SR2 = 3'd5; RD_EN = 1'b1;
    @(negedge Clk);
    RD_EN = 1'b0;
    check("wr_sr1", 64'(SR1_out), 64'h1234);
    check("wr_sr2", 64'(SR2_out), 64'hBEEF);
    check("wr_valid", 64'(RD_VALID), 64'd1);
    @(negedge Clk);
    check("wr_valid_off", 64'(RD_VALID), 64'd0);
    check("wr_hold", 64'(SR1_out), 64'h1234);

    LD_REG = 1'b1; DR = 3'd4; D = 16'h0001;
    @(negedge Clk);
    D = 16'h00FF; RD_EN = 1'b1; SR1 = 3'd4; SR2 = 3'd5;
    @(negedge Clk);
    LD_REG = 1'b0; RD_EN = 1'b0;
    check("coll_sr1", 64'(SR1_out), BYPASS ? 64'h00FF : 64'h0001);
    check("coll_sr2", 64'(SR2_out), 64'hBEEF);
    SR1 = 3'd4; SR2 = 3'd4; RD_EN = 1'b1;
    @(negedge Clk);
    RD_EN = 1'b0;
    check("same_sr1", 64'(SR1_out), 64'h00FF);
    check("same_sr2", 64'(SR2_out), 64'h00FF);

    LD_CC = 1'b1; CC_SRC = 16'h8000;
    @(negedge Clk);
    check("cc_neg", 64'(NZP), 64'(3'b100));
    CC_SRC = 16'h0000;
    @(negedge Clk);
    check("cc_zero", 64'(NZP), 64'(3'b010));
    CC_SRC = 16'h0001;
    @(negedge Clk);
    LD_CC = 1'b0;
    check("cc_pos", 64'(NZP), 64'(3'b001));
    LD_BEN = 1'b1; NZP_MASK = 3'b001;
    @(negedge Clk);
    check("ben_hit", 64'(BEN), 64'd1);
    NZP_MASK = 3'b110;
    @(negedge Clk);
    LD_BEN = 1'b0;
    check("ben_miss", 64'(BEN), 64'd0);
    LD_CC = 1'b1; CC_SRC = 16'h8000; LD_BEN = 1'b1; NZP_MASK = 3'b001;
    @(negedge Clk);
    LD_CC = 1'b0; LD_BEN = 1'b0;
    check("ben_old_nzp", 64'(BEN), 64'd1);
    check("nzp_same_edge", 64'(NZP), 64'(3'b100));

    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("mid_busy", 64'(BUSY), 64'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    LD_REG = 1'b1; DR = 3'd1; D = 16'hAAAA;
    RD_EN = 1'b1; SR1 = 3'd1; SR2 = 3'd1;
    LD_CC = 1'b1; CC_SRC = 16'h0000;
    wait_busy(cyc);
    LD_REG = 1'b0; RD_EN = 1'b0; LD_CC = 1'b0;
    check("mid_sweep_len", 64'(cyc), 64'd8);
    check("cc_during_busy", 64'(NZP), 64'(3'b010));
    SR1 = 3'd1; SR2 = 3'd2; RD_EN = 1'b1;
    @(negedge Clk);
    RD_EN = 1'b0;
    check("gated_wr_r1", 64'(SR1_out), 64'd0);
    check("cleared_r2", 64'(SR2_out), 64'd0);
    check("post_valid", 64'(RD_VALID), 64'd1);

    w_Reset = 1'b0;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (w_BUSY && cyc < 100);
    check("w_sweep_len", 64'(cyc), 64'd16);
    w_LD_REG = 1'b1; w_DR = 4'd15; w_D = 32'h8000_0000;
    @(negedge Clk);
    w_LD_REG = 1'b0; w_RD_EN = 1'b1; w_SR1 = 4'd15; w_SR2 = 4'd0;
    w_LD_CC = 1'b1; w_CC_SRC = 32'h8000_0000;
    @(negedge Clk);
    w_RD_EN = 1'b0; w_LD_CC = 1'b0;
    check("w_sr1", 64'(w_SR1_out), 64'h8000_0000);
    check("w_sr2", 64'(w_SR2_out), 64'd0);
    check("w_valid", 64'(w_RD_VALID), 64'd1);
    check("w_nzp", 64'(w_NZP), 64'(3'b100));

    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lc3_regfile_sync.md
Name: lc3_regfile_sync

Overview:
- Parametrised successor to the LC-3 register file and NZP/BEN logic.
- Holds the general-purpose registers in an array that maps onto MAX10 M9K block RAM, so both read ports are synchronous with 1-cycle latency.
- Block RAM cannot be cleared in one cycle, so contents are zeroed by a post-reset sweep state machine.
- Also owns the condition codes (NZP) and the branch-enable flag (BEN). Sits between the bus, IR decode and the control FSM.

Parameters:
- DATA_W, 16, register and bus width in bits (>=2).
- NREGS, 8, number of registers; power of 2, >=2.
- ADDR_W, $clog2(NREGS), register index width; derived, do not override.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- LD_REG  in  1  write enable.
- DR  in  ADDR_W  write index.
- D  in  DATA_W  write data.
- RD_EN  in  1  read request; samples SR1/SR2.
- SR1  in  ADDR_W  read index, port 1.
- SR2  in  ADDR_W  read index, port 2.
- SR1_out  out  DATA_W  registered read data, port 1.
- SR2_out  out  DATA_W  registered read data, port 2.
- RD_VALID  out  1  one-cycle pulse: SRx_out are fresh.
- BUSY  out  1  high while the clear sweep runs.
- LD_CC  in  1  update NZP from CC_SRC.
- CC_SRC  in  DATA_W  value to classify (normally the bus).
- LD_BEN  in  1  update BEN.
- NZP_MASK  in  3  branch mask {n,z,p} (IR[11:9]).
- NZP  out  3  condition codes {N,Z,P}.
- BEN  out  1  branch enable.

Behaviour:
- Reset values:
  - SR1_out = SR2_out = 0.
  - RD_VALID = 0, BUSY = 1.
  - NZP = 3'b010, BEN = 0.
  - State = CLEAR, clr_ptr = 0.
- State machine CLEAR -> READY:
  - CLEAR with Reset low: write 0 to reg[clr_ptr], then clr_ptr++.
  - When clr_ptr == NREGS-1 is written, go to READY next edge.
  - BUSY deasserts in the cycle after the last clear write, i.e. exactly NREGS cycles after Reset falls.
- Reset while Reset is held: state stays CLEAR with clr_ptr held at 0.
- Reset asserted mid-sweep or in READY: sweep restarts from 0. Partially cleared contents are don't-care until BUSY falls.
- While BUSY:
  - LD_REG and RD_EN are ignored.
  - RD_VALID stays 0.
  - SRx_out hold.
- Write (READY): reg[DR] <= D at the edge where LD_REG = 1.
- Read (READY):
  - RD_EN = 1 at edge t loads SR1_out/SR2_out from the array.
  - RD_VALID = 1 for the cycle after t.
  - Without RD_EN, RD_VALID = 0 and SRx_out hold their last value.
- SR1 == SR2 is legal; both ports return the same data.
- Same-edge write and read to the same index: result is set by the optional feature below.
- CC update on LD_CC: N = CC_SRC[DATA_W-1]; Z = (CC_SRC == 0); P = otherwise. Exactly one bit is set at all times.
- BEN update on LD_BEN: BEN <= |(NZP_MASK & NZP), using the registered NZP.
- LD_CC and LD_BEN on the same edge: BEN uses the pre-update NZP.
- CC/BEN are independent of BUSY and operate during the sweep.

Optional Feature:
- Macro: LC3_REGFILE_WRITE_BYPASS_EN.
- Defined (write-first): when RD_EN, LD_REG and SRx == DR coincide on one edge, SRx_out <= D. This costs a comparator and mux per port.
- Undefined (read-first): SRx_out <= old reg[SRx]; the new value is visible on the next read.
- All other behaviour is identical in both builds.

Decomposition:
- Package lc3_pkg:
  - rf_state_t enum {CLEAR, READY}.
  - nzp_t packed struct {n,z,p}.
  - NZP_RESET = 3'b010.
  - Helper function nzp_of(value) returning nzp_t.
- One sub-module, lc3_cc_unit: NZP and BEN registers plus classification; ports Clk, Reset, LD_CC, CC_SRC, LD_BEN, NZP_MASK, NZP, BEN.
- Top module holds the array, read registers, bypass and sweep FSM.

Test Plan:
- Sweep: pulse Reset for 3 cycles, release -> BUSY high for exactly 8 cycles. Then RD_EN with SR1=3, SR2=7 -> next cycle RD_VALID=1, SR1_out=0, SR2_out=0.
- Write/read: write R2=16'h1234, R5=16'hBEEF; RD_EN with SR1=2, SR2=5 -> after 1 cycle SR1_out=1234, SR2_out=BEEF, RD_VALID pulses once.
- Same-edge collision: R4=16'h0001; on one edge LD_REG DR=4 D=16'h00FF with RD_EN SR1=4 -> SR1_out=00FF with the bypass macro, 0001 without it.
- Mid-sweep reset and BUSY gating: assert Reset 3 cycles into the sweep -> BUSY stays high for 8 cycles after release. LD_REG DR=1 D=16'hAAAA issued during BUSY -> a later read of R1 returns 0.
- CC/BEN:
  - LD_CC with CC_SRC=8000 -> NZP=100; with 0000 -> 010; with 0001 -> 001.
  - NZP=001, then LD_BEN with mask 3'b001 -> BEN=1; mask 3'b110 -> BEN=0.
  - LD_CC=8000 and LD_BEN mask 001 on the same edge -> BEN=1, NZP=100.
- Parametrised build DATA_W=32, NREGS=16: BUSY lasts 16 cycles; write R15=32'h8000_0000, read it back, LD_CC from the same value -> NZP=100.
